// File: rtl/micro_pkg.sv
// Shared types and constants for the 9-bit micro sequencer slice.
package micro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD_IMM = 3'd0,
    OP_LOAD_MEM = 3'd1,
    OP_MATH     = 3'd5,
    OP_JMP      = 3'd6,
    OP_NOP      = 3'd7
  } opcode_t;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;
  localparam logic [8:0] NOP_INSTR  = 9'h1C0;
  localparam logic [1:0] BIU_NONE   = 2'b11;
  localparam logic [3:0] COND_NONE  = 4'hF;
  localparam logic [3:0] COND_CALL  = 4'h1;

  // Bit positions inside the {V,N,C,Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/micro_sequencer_if.sv
// Program/data memory handshake between the sequencer (master) and the BIU side.
interface micro_sequencer_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] o_PC;
  logic            o_Fetch_Req;
  logic            o_Mem_Req;
  logic [8:0]      i_Instr_Data;
  logic            i_Mem_Ready;

  modport master (
    output o_PC, o_Fetch_Req, o_Mem_Req,
    input  i_Instr_Data, i_Mem_Ready
  );

  modport slave (
    input  o_PC, o_Fetch_Req, o_Mem_Req,
    output i_Instr_Data, i_Mem_Ready
  );
endinterface

// File: rtl/micro_cond_eval.sv
// Jump-condition evaluator: decoder condition code against the ALU flags.
module micro_cond_eval
  import micro_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_taken
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_taken = 1'b0;
    if (i_cond != COND_NONE && !i_cond[3]) begin
      unique case (i_cond[2:0])
        3'd0, 3'd1: o_taken = 1'b1;
        3'd2:       o_taken = i_flags[FLAG_Z];
        3'd3:       o_taken = !i_flags[FLAG_Z];
        3'd4:       o_taken = i_flags[FLAG_C];
        3'd5:       o_taken = !i_flags[FLAG_C];
        3'd6:       o_taken = i_flags[FLAG_N];
        3'd7:       o_taken = i_flags[FLAG_V];
        default:    o_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Fetch/decode/execute controller: owns PC and instruction register, runs the
// memory handshake with a timeout, and gates register-file and flag writes.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter int              MEM_TIMEOUT = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Run,
  micro_sequencer_if.master bus,
  input  logic [1:0]        i_SEL_BIU,
  input  logic              i_R_W,
  input  logic [3:0]        i_COND,
  input  logic [3:0]        i_Flags,
  input  logic [PC_W-1:0]   i_Jump_Target,
  output logic [8:0]        o_Instruction,
  output logic              o_Reg_WE,
  output logic              o_Flags_WE,
  output logic [PC_W-1:0]   o_Link_PC,
  output logic              o_Halted,
  output logic              o_Fault
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 2);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [8:0]      r_instr;
  logic            r_fetch_req;
  logic            r_mem_req;
  logic            r_reg_we;
  logic            r_flags_we;
  logic [PC_W-1:0] r_link_pc;
  logic            r_halted;
  logic            r_fault;
  logic [CNT_W-1:0] r_cnt;

  logic            w_taken;
  logic            w_waiting;
  logic [PC_W-1:0] w_pc_inc;

  micro_cond_eval u_cond_eval (
    .i_cond  (i_COND),
    .i_flags (i_Flags),
    .o_taken (w_taken)
  );

  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_waiting = (r_state == ST_FETCH || r_state == ST_MEM) && !bus.i_Mem_Ready;

  // NOTE: sequential state uses non-blocking assignments only; strobes default low
  // at the top of the block and a later assignment in the same cycle overrides it.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_fetch_req <= 1'b0;
      r_mem_req   <= 1'b0;
      r_reg_we    <= 1'b0;
      r_flags_we  <= 1'b0;
      r_link_pc   <= '0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_reg_we   <= 1'b0;
      r_flags_we <= 1'b0;
      if (w_waiting) begin
        // A ready on the expiry cycle never reaches here, so ready wins the tie.
        if (r_cnt == CNT_LAST) begin
          r_fault     <= 1'b1;
          r_halted    <= 1'b1;
          r_state     <= ST_HALT;
          r_fetch_req <= 1'b0;
          r_mem_req   <= 1'b0;
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (i_Run) begin
              r_state     <= ST_FETCH;
              r_fetch_req <= 1'b1;
              r_cnt       <= '0;
            end
          end
          ST_FETCH: begin
            r_instr     <= bus.i_Instr_Data;
            r_fetch_req <= 1'b0;
            r_cnt       <= '0;
            if (bus.i_Instr_Data == HALT_INSTR) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= ST_DECODE;
            end
          end
          ST_DECODE: r_state <= ST_EXEC;
          ST_EXEC: begin
            if (i_SEL_BIU != BIU_NONE) begin
              r_state   <= ST_MEM;
              r_mem_req <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_reg_we    <= i_R_W | (w_taken && i_COND == COND_CALL);
              r_flags_we  <= (r_instr[8:6] == OP_MATH);
              r_link_pc   <= w_pc_inc;
              r_pc        <= w_taken ? i_Jump_Target : w_pc_inc;
              r_state     <= i_Run ? ST_FETCH : ST_IDLE;
              r_fetch_req <= i_Run;
              r_cnt       <= '0;
            end
          end
          ST_MEM: begin
            r_mem_req   <= 1'b0;
            r_reg_we    <= i_R_W;
            r_link_pc   <= w_pc_inc;
            r_pc        <= w_pc_inc;
            r_state     <= i_Run ? ST_FETCH : ST_IDLE;
            r_fetch_req <= i_Run;
            r_cnt       <= '0;
          end
          ST_HALT: r_state <= ST_HALT;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_PC        = r_pc;
  assign bus.o_Fetch_Req = r_fetch_req;
  assign bus.o_Mem_Req   = r_mem_req;
  assign o_Instruction   = r_instr;
  assign o_Reg_WE        = r_reg_we;
  assign o_Flags_WE      = r_flags_we;
  assign o_Link_PC       = r_link_pc;
  assign o_Halted        = r_halted;
  assign o_Fault         = r_fault;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: an instruction-level model predicts fetch
// addresses, write strobes and data-request lengths; a monitor compares them.
module tb_micro_sequencer;

  localparam int PC_W        = 8;
  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Run = 1'b0;
  logic [1:0] i_SEL_BIU = 2'b11;
  logic       i_R_W = 1'b0;
  logic [3:0] i_COND = 4'hF;
  logic [3:0] i_Flags = 4'h0;
  logic [7:0] i_Jump_Target = 8'h00;
  logic [8:0] o_Instruction;
  logic       o_Reg_WE;
  logic       o_Flags_WE;
  logic [7:0] o_Link_PC;
  logic       o_Halted;
  logic       o_Fault;

  micro_sequencer_if #(.PC_W(PC_W)) bus ();

  micro_sequencer #(
    .PC_W        (PC_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .RESET_PC    (8'h00)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (i_Reset),
    .i_Run         (i_Run),
    .bus           (bus),
    .i_SEL_BIU     (i_SEL_BIU),
    .i_R_W         (i_R_W),
    .i_COND        (i_COND),
    .i_Flags       (i_Flags),
    .i_Jump_Target (i_Jump_Target),
    .o_Instruction (o_Instruction),
    .o_Reg_WE      (o_Reg_WE),
    .o_Flags_WE    (o_Flags_WE),
    .o_Link_PC     (o_Link_PC),
    .o_Halted      (o_Halted),
    .o_Fault       (o_Fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fetch_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard queues ----------------
  typedef struct {
    logic       reg_we;
    logic       flags_we;
    logic       is_call;
    logic [7:0] link;
    logic [7:0] pc;
  } strobe_t;

  strobe_t    exp_strobe[$];
  logic [7:0] exp_fetch[$];
  int         exp_mlen[$];
  logic [7:0] m_pc = 8'h00;

  function automatic bit cond_taken(input logic [3:0] c, input logic [3:0] f);
    bit z, cy, n, v;
    z  = f[0];
    cy = f[1];
    n  = f[2];
    v  = f[3];
    if (c[3]) return 1'b0;
    case (c[2:0])
      3'd0, 3'd1: return 1'b1;
      3'd2:       return z;
      3'd3:       return !z;
      3'd4:       return cy;
      3'd5:       return !cy;
      3'd6:       return n;
      default:    return v;
    endcase
  endfunction

  task automatic model_step(input logic [8:0] instr, input logic [1:0] sel, input logic rw,
                            input logic [3:0] cond, input logic [3:0] flags, input logic [7:0] tgt);
    strobe_t    s;
    bit         mem, taken, call;
    logic [7:0] nxt;
    if (instr == 9'h1FF) return;
    mem   = (sel != 2'b11);
    taken = !mem && cond_taken(cond, flags);
    call  = taken && (cond == 4'h1);
    nxt   = taken ? tgt : m_pc + 8'd1;
    s.reg_we   = rw || call;
    s.flags_we = !mem && (instr[8:6] == 3'd5);
    s.is_call  = call;
    s.link     = m_pc + 8'd1;
    s.pc       = nxt;
    if (s.reg_we || s.flags_we) exp_strobe.push_back(s);
    exp_fetch.push_back(nxt);
    m_pc = nxt;
  endtask

  // ---------------- monitor ----------------
  bit         prev_fetch = 1'b0;
  bit         prev_mem = 1'b0;
  int         mlen = 0;
  strobe_t    got_s;
  logic [7:0] got_pc;
  int         got_len;

  always @(negedge clk) begin
    if (i_Reset) begin
      prev_fetch = 1'b0;
      prev_mem   = 1'b0;
      mlen       = 0;
    end else begin
      check("req_exclusive", {31'd0, bus.o_Fetch_Req & bus.o_Mem_Req}, 32'd0);
      if (bus.o_Fetch_Req && !prev_fetch) begin
        check("fetch_expected", {31'd0, exp_fetch.size() > 0}, 32'd1);
        if (exp_fetch.size() > 0) begin
          got_pc = exp_fetch.pop_front();
          check("fetch_pc", {24'd0, bus.o_PC}, {24'd0, got_pc});
        end
      end
      if (o_Reg_WE || o_Flags_WE) begin
        check("strobe_expected", {31'd0, exp_strobe.size() > 0}, 32'd1);
        if (exp_strobe.size() > 0) begin
          got_s = exp_strobe.pop_front();
          check("reg_we", {31'd0, o_Reg_WE}, {31'd0, got_s.reg_we});
          check("flags_we", {31'd0, o_Flags_WE}, {31'd0, got_s.flags_we});
          check("pc_after", {24'd0, bus.o_PC}, {24'd0, got_s.pc});
          if (got_s.is_call) check("link_pc", {24'd0, o_Link_PC}, {24'd0, got_s.link});
        end
      end
      if (bus.o_Mem_Req) begin
        mlen++;
      end else if (prev_mem) begin
        check("mem_expected", {31'd0, exp_mlen.size() > 0}, 32'd1);
        if (exp_mlen.size() > 0) begin
          got_len = exp_mlen.pop_front();
          check("mem_req_len", mlen, got_len);
        end
        mlen = 0;
      end
      prev_fetch = bus.o_Fetch_Req;
      prev_mem   = bus.o_Mem_Req;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic reset_dut(input bit clean);
    if (clean) begin
      repeat (4) @(negedge clk);
      check("sb_fetch_drained", exp_fetch.size(), 32'd0);
      check("sb_strobe_drained", exp_strobe.size(), 32'd0);
      check("sb_mem_drained", exp_mlen.size(), 32'd0);
    end
    i_Reset = 1'b1;
    i_Run = 1'b0;
    bus.i_Mem_Ready = 1'b0;
    @(negedge clk);
    check("rst_pc", {24'd0, bus.o_PC}, 32'h00);
    check("rst_instr", {23'd0, o_Instruction}, 32'h1C0);
    check("rst_fetch_req", {31'd0, bus.o_Fetch_Req}, 32'd0);
    check("rst_mem_req", {31'd0, bus.o_Mem_Req}, 32'd0);
    check("rst_reg_we", {31'd0, o_Reg_WE}, 32'd0);
    check("rst_flags_we", {31'd0, o_Flags_WE}, 32'd0);
    check("rst_halted", {31'd0, o_Halted}, 32'd0);
    check("rst_fault", {31'd0, o_Fault}, 32'd0);
    @(negedge clk);
    exp_fetch.delete();
    exp_strobe.delete();
    exp_mlen.delete();
    m_pc = 8'h00;
    exp_fetch.push_back(8'h00);
    i_Reset = 1'b0;
  endtask

  task automatic run_instr(input logic [8:0] instr, input logic [1:0] sel, input logic rw,
                           input logic [3:0] cond, input logic [3:0] flags, input logic [7:0] tgt,
                           input int fwait, input int mwait, input bit drop_run);
    int t;
    i_Run = 1'b1;
    t = 0;
    while (!bus.o_Fetch_Req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("fetch_arrives", {31'd0, bus.o_Fetch_Req}, 32'd1);
    if (!bus.o_Fetch_Req) return;
    repeat (fwait) @(negedge clk);
    bus.i_Mem_Ready  = 1'b1;
    bus.i_Instr_Data = instr;
    i_SEL_BIU        = sel;
    i_R_W            = rw;
    i_COND           = cond;
    i_Flags          = flags;
    i_Jump_Target    = tgt;
    last_fetch_cyc   = cyc;
    if (drop_run) i_Run = 1'b0;
    model_step(instr, sel, rw, cond, flags, tgt);
    @(negedge clk);
    bus.i_Mem_Ready = 1'b0;
    if (instr == 9'h1FF) return;
    if (sel != 2'b11) begin
      t = 0;
      while (!bus.o_Mem_Req && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("mem_req_arrives", {31'd0, bus.o_Mem_Req}, 32'd1);
      if (!bus.o_Mem_Req) return;
      exp_mlen.push_back(mwait + 1);
      repeat (mwait) @(negedge clk);
      bus.i_Mem_Ready = 1'b1;
      @(negedge clk);
      bus.i_Mem_Ready = 1'b0;
    end
    if (drop_run) begin
      repeat (3) @(negedge clk);
      check("idle_fetch_req", {31'd0, bus.o_Fetch_Req}, 32'd0);
      check("idle_mem_req", {31'd0, bus.o_Mem_Req}, 32'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int         c0, n, t;
    logic [7:0] pc_hold;
    logic [8:0] r_ins;
    logic [1:0] r_sel;

    bus.i_Mem_Ready  = 1'b0;
    bus.i_Instr_Data = 9'h1C0;
    reset_dut(1'b0);

    // Zero-wait straight-line code: 3 cycles per instruction.
    run_instr(9'h008, 2'b11, 1'b1, 4'hF, 4'h0, 8'h00, 0, 0, 1'b0);
    c0 = last_fetch_cyc;
    run_instr(9'h1C0, 2'b11, 1'b0, 4'hF, 4'h0, 8'h00, 0, 0, 1'b0);
    check("instr_cycles", last_fetch_cyc - c0, 32'd3);
    run_instr(9'h140, 2'b11, 1'b1, 4'hF, 4'h0, 8'h00, 0, 0, 1'b0);

    // Load through the BIU with three wait states.
    run_instr(9'h04A, 2'b00, 1'b1, 4'hF, 4'h0, 8'h00, 0, 3, 1'b0);

    // Conditional jump on Z, taken then not taken.
    run_instr(9'h182, 2'b11, 1'b0, 4'h2, 4'b0001, 8'h40, 0, 0, 1'b0);
    run_instr(9'h182, 2'b11, 1'b0, 4'h2, 4'b0000, 8'h99, 1, 0, 1'b0);

    // Call from 0x10 to 0x80.
    run_instr(9'h180, 2'b11, 1'b0, 4'h0, 4'h0, 8'h10, 0, 0, 1'b0);
    run_instr(9'h181, 2'b11, 1'b0, 4'h1, 4'h0, 8'h80, 0, 0, 1'b0);

    // PC wrap from 0xFF.
    run_instr(9'h180, 2'b11, 1'b0, 4'h0, 4'h0, 8'hFF, 0, 0, 1'b0);
    run_instr(9'h1C0, 2'b11, 1'b0, 4'hF, 4'h0, 8'h00, 0, 0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      r_ins = 9'($urandom_range(0, 9'h1FE));
      r_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      run_instr(r_ins, r_sel, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                $urandom_range(0, 3), $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
    end

    // HALT instruction freezes the PC until reset.
    run_instr(9'h1FF, 2'b11, 1'b0, 4'hF, 4'h0, 8'h00, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    pc_hold = bus.o_PC;
    check("halt_halted", {31'd0, o_Halted}, 32'd1);
    check("halt_instr", {23'd0, o_Instruction}, 32'h1FF);
    check("halt_pc", {24'd0, pc_hold}, {24'd0, m_pc});
    repeat (5) @(negedge clk);
    check("halt_pc_frozen", {24'd0, bus.o_PC}, {24'd0, m_pc});
    check("halt_no_fetch", {31'd0, bus.o_Fetch_Req}, 32'd0);
    check("halt_no_fault", {31'd0, o_Fault}, 32'd0);
    reset_dut(1'b1);

    // Fetch never acknowledged: fault after MEM_TIMEOUT-1 request cycles.
    i_Run = 1'b1;
    t = 0;
    while (!bus.o_Fetch_Req && t < 10) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    while (bus.o_Fetch_Req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", n, MEM_TIMEOUT - 1);
    check("timeout_fault", {31'd0, o_Fault}, 32'd1);
    check("timeout_halted", {31'd0, o_Halted}, 32'd1);
    check("timeout_fetch_req", {31'd0, bus.o_Fetch_Req}, 32'd0);
    check("timeout_mem_req", {31'd0, bus.o_Mem_Req}, 32'd0);
    reset_dut(1'b1);

    // Ready on the very cycle the counter expires: no fault.
    run_instr(9'h1C0, 2'b11, 1'b0, 4'hF, 4'h0, 8'h00, MEM_TIMEOUT - 2, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("edge_ready_no_fault", {31'd0, o_Fault}, 32'd0);
    check("edge_ready_not_halted", {31'd0, o_Halted}, 32'd0);
    reset_dut(1'b1);

    // Reset while a data access is outstanding.
    i_Run = 1'b1;
    t = 0;
    while (!bus.o_Fetch_Req && t < 10) begin
      @(negedge clk);
      t++;
    end
    bus.i_Mem_Ready  = 1'b1;
    bus.i_Instr_Data = 9'h04A;
    i_SEL_BIU        = 2'b00;
    i_R_W            = 1'b1;
    @(negedge clk);
    bus.i_Mem_Ready = 1'b0;
    t = 0;
    while (!bus.o_Mem_Req && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("midmem_req_seen", {31'd0, bus.o_Mem_Req}, 32'd1);
    repeat (2) @(negedge clk);
    reset_dut(1'b0);
    @(negedge clk);
    check("post_reset_idle_fetch", {31'd0, bus.o_Fetch_Req}, 32'd0);
    check("post_reset_idle_mem", {31'd0, bus.o_Mem_Req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
